mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/memwb_pkg.sv | 45 ++++
 rtl/mem_wb_stage_load_extract.sv | 50 +++++
 rtl/mem_wb_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// -----------------------------------------------------------------------------
// memwb_pkg
// Purpose : Shared encodings and width constants for the MEM/WB pipeline stage.
//           Holds the write-back source select encoding, the load-type
//           encoding, data/register widths and the misaligned-load helper.
// Ports   : (package, no ports)
// Config  : load_misaligned() is only called when MEMWB_ALIGN_CHECK_EN is
//           defined.
// -----------------------------------------------------------------------------
package memwb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // Write-back data source. WB_ALU_ALT decodes the same as WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_LOAD    = 2'b01,
        WB_LINK    = 2'b10,
        WB_ALU_ALT = 2'b11
    } wb_sel_e;

    // Load width/extension. Unlisted codes decode as LT_LW.
    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_type_e;

    // A word load needs a word-aligned address, a halfword load needs an
    // even address, byte loads can never be misaligned.
    function automatic logic load_misaligned(input logic [2:0] load_type,
                                             input logic [1:0] addr_lo);
        logic mis;
        case (load_type)
            LT_LH, LT_LHU: mis = addr_lo[0];
            LT_LB, LT_LBU: mis = 1'b0;
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage : memwb_pkg

// File: rtl/mem_wb_stage_load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Purpose : Combinational little-endian load data aligner/extender.
//           Picks the byte or halfword addressed by addr_lo out of the memory
//           read word and sign- or zero-extends it to 32 bits.
// Ports   : rdata     in  32  raw memory read word
//           load_type in  3   load encoding (memwb_pkg::load_type_e)
//           addr_lo   in  2   byte offset of the load address
//           result    out 32  extended load value
// -----------------------------------------------------------------------------
module load_extract
    import memwb_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      load_type,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword; halfword choice ignores addr_lo[0].
    always_comb begin
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected field according to the load type.
    always_comb begin
        case (load_type)
            LT_LH:   result = {{16{half_s[15]}}, half_s};
            LT_LHU:  result = {16'h0000, half_s};
            LT_LB:   result = {{24{byte_s[7]}}, byte_s};
            LT_LBU:  result = {24'h000000, byte_s};
            default: result = rdata;
        endcase
    end

endmodule : load_extract

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Purpose : MEM/WB pipeline register plus write-back data selection.
//           Captures the memory-stage results, drives the register-file write
//           port and counts retired instructions.
// Ports   : clock             in  1   rising-edge clock
//           Reset             in  1   asynchronous active-low reset
//           stall             in  1   hold stage contents
//           flush             in  1   invalidate stage contents (wins over stall)
//           in_valid          in  1   incoming instruction valid
//           in_reg_write      in  1   instruction writes a register
//           in_wb_sel         in  2   write-back source select
//           in_load_type      in  3   load encoding
//           in_addr_lo        in  2   load byte offset
//           in_alu_result     in  32  ALU result
//           in_mem_rdata      in  32  memory read word
//           in_pc_plus4       in  32  link value
//           in_dest           in  5   destination register
//           reg_write_enable  out 1   register-file write enable
//           reg_write_address out 5   register-file write address
//           write_data        out 32  register-file write data
//           wb_valid          out 1   stage holds a valid instruction
//           align_err         out 1   misaligned load (only with MEMWB_ALIGN_CHECK_EN)
//           retire_count      out 32  retired-instruction counter
// Config  : MEMWB_ALIGN_CHECK_EN adds align_err and suppresses write-back and
//           retirement of misaligned loads.
// -----------------------------------------------------------------------------
module mem_wb_stage
    import memwb_pkg::*;
(
    input  logic              clock,
    input  logic              Reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_mem_rdata,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [REG_AW-1:0] in_dest,
    output logic              reg_write_enable,
    output logic [REG_AW-1:0] reg_write_address,
    output logic [XLEN-1:0]   write_data,
    output logic              wb_valid,
`ifdef MEMWB_ALIGN_CHECK_EN
    output logic              align_err,
`endif
    output logic [XLEN-1:0]   retire_count
);

    logic              valid_q,        valid_d;
    logic              reg_write_q,    reg_write_d;
    logic [1:0]        wb_sel_q,       wb_sel_d;
    logic [2:0]        load_type_q,    load_type_d;
    logic [1:0]        addr_lo_q,      addr_lo_d;
    logic [XLEN-1:0]   alu_result_q,   alu_result_d;
    logic [XLEN-1:0]   mem_rdata_q,    mem_rdata_d;
    logic [XLEN-1:0]   pc_plus4_q,     pc_plus4_d;
    logic [REG_AW-1:0] dest_q,         dest_d;
    logic [XLEN-1:0]   retire_count_q, retire_count_d;

    logic [XLEN-1:0]   load_data_s;
    logic              misalign_s;
    logic              retire_s;

    load_extract u_load_extract (
        .rdata     (mem_rdata_q),
        .load_type (load_type_q),
        .addr_lo   (addr_lo_q),
        .result    (load_data_s)
    );

`ifdef MEMWB_ALIGN_CHECK_EN
    assign misalign_s = valid_q & (wb_sel_q == WB_LOAD) & load_misaligned(load_type_q, addr_lo_q);
    assign align_err  = misalign_s;
`else
    assign misalign_s = 1'b0;
`endif

    // An instruction leaves the stage on any unstalled edge; a stalled one is
    // counted only when it finally moves on.
    assign retire_s = valid_q & ~stall & ~misalign_s;

    // Next-state for the pipeline register: flush kills valid, stall holds.
    always_comb begin
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        wb_sel_d       = wb_sel_q;
        load_type_d    = load_type_q;
        addr_lo_d      = addr_lo_q;
        alu_result_d   = alu_result_q;
        mem_rdata_d    = mem_rdata_q;
        pc_plus4_d     = pc_plus4_q;
        dest_d         = dest_q;
        retire_count_d = retire_count_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d      = in_valid;
            reg_write_d  = in_reg_write;
            wb_sel_d     = in_wb_sel;
            load_type_d  = in_load_type;
            addr_lo_d    = in_addr_lo;
            alu_result_d = in_alu_result;
            mem_rdata_d  = in_mem_rdata;
            pc_plus4_d   = in_pc_plus4;
            dest_d       = in_dest;
        end else begin
            valid_d = valid_q;
        end
        if (retire_s) begin
            retire_count_d = retire_count_q + 32'd1;
        end else begin
            retire_count_d = retire_count_q;
        end
    end

    // Pipeline register and retire counter with asynchronous clear.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            wb_sel_q       <= 2'b00;
            load_type_q    <= 3'b000;
            addr_lo_q      <= 2'b00;
            alu_result_q   <= 32'h0000_0000;
            mem_rdata_q    <= 32'h0000_0000;
            pc_plus4_q     <= 32'h0000_0000;
            dest_q         <= 5'd0;
            retire_count_q <= 32'h0000_0000;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            wb_sel_q       <= wb_sel_d;
            load_type_q    <= load_type_d;
            addr_lo_q      <= addr_lo_d;
            alu_result_q   <= alu_result_d;
            mem_rdata_q    <= mem_rdata_d;
            pc_plus4_q     <= pc_plus4_d;
            dest_q         <= dest_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Write-back data mux; the reserved select code behaves as ALU.
    always_comb begin
        case (wb_sel_q)
            WB_LOAD: write_data = load_data_s;
            WB_LINK: write_data = pc_plus4_q;
            default: write_data = alu_result_q;
        endcase
    end

    // r0 is hard-wired zero, so it is never written.
    assign reg_write_enable  = valid_q & reg_write_q & (dest_q != 5'd0) & ~misalign_s;
    assign reg_write_address = dest_q;
    assign wb_valid          = valid_q;
    assign retire_count      = retire_count_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Purpose : Self-checking bench for mem_wb_stage: a table of single-cycle
//           vectors followed by hand-written stall, flush, wrap, reset and
//           alignment sequences.
// Config  : honours MEMWB_ALIGN_CHECK_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clock;
    logic        Reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic [4:0]  in_dest;
    logic        reg_write_enable;
    logic [4:0]  reg_write_address;
    logic [31:0] write_data;
    logic        wb_valid;
    logic [31:0] retire_count;
`ifdef MEMWB_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int n_checks;
    int n_fail;

    mem_wb_stage dut (
        .clock             (clock),
        .Reset             (Reset),
        .stall             (stall),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_reg_write      (in_reg_write),
        .in_wb_sel         (in_wb_sel),
        .in_load_type      (in_load_type),
        .in_addr_lo        (in_addr_lo),
        .in_alu_result     (in_alu_result),
        .in_mem_rdata      (in_mem_rdata),
        .in_pc_plus4       (in_pc_plus4),
        .in_dest           (in_dest),
        .reg_write_enable  (reg_write_enable),
        .reg_write_address (reg_write_address),
        .write_data        (write_data),
        .wb_valid          (wb_valid),
`ifdef MEMWB_ALIGN_CHECK_EN
        .align_err         (align_err),
`endif
        .retire_count      (retire_count)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  dest;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic [31:0] exp_rc;
    } vec_t;

    vec_t vecs [0:13];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic vld, input logic [31:0] rc);
        cmp({tag, ".we"},    {31'd0, reg_write_enable}, {31'd0, we});
        cmp({tag, ".addr"},  {27'd0, reg_write_address}, {27'd0, addr});
        cmp({tag, ".data"},  write_data, data);
        cmp({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, vld});
        cmp({tag, ".rc"},    retire_count, rc);
    endtask

    // Wait for the falling edge, then present new inputs.
    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4, input logic [4:0] dest,
                         input logic st, input logic fl);
        @(negedge clock);
        in_valid      = v;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_load_type  = lt;
        in_addr_lo    = alo;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_pc_plus4   = pc4;
        in_dest       = dest;
        stall         = st;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //                 v     rw    sel    lt     alo    alu           rdata         pc4           dest   we    addr   data          vld   rc
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h12345678, 32'h0,        32'h0,        5'd5,  1'b1, 5'd5,  32'h12345678, 1'b1, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 3'b011, 2'b11, 32'h0,        32'h80FF7F01, 32'h0,        5'd7,  1'b1, 5'd7,  32'hFFFFFF80, 1'b1, 32'd1};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 3'b100, 2'b11, 32'h0,        32'h80FF7F01, 32'h0,        5'd7,  1'b1, 5'd7,  32'h00000080, 1'b1, 32'd2};
        vecs[3]  = '{1'b1, 1'b1, 2'b01, 3'b001, 2'b10, 32'h0,        32'h80FF7F01, 32'h0,        5'd7,  1'b1, 5'd7,  32'hFFFF80FF, 1'b1, 32'd3};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 3'b010, 2'b00, 32'h0,        32'h80FF7F01, 32'h0,        5'd12, 1'b1, 5'd12, 32'h00007F01, 1'b1, 32'd4};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 3'b011, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5'd12, 1'b1, 5'd12, 32'h0000007F, 1'b1, 32'd5};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 3'b000, 2'b00, 32'h0,        32'h80FF7F01, 32'h0,        5'd13, 1'b1, 5'd13, 32'h80FF7F01, 1'b1, 32'd6};
        vecs[7]  = '{1'b1, 1'b1, 2'b10, 3'b000, 2'b00, 32'h55,       32'h0,        32'h00001004, 5'd1,  1'b1, 5'd1,  32'h00001004, 1'b1, 32'd7};
        vecs[8]  = '{1'b1, 1'b1, 2'b11, 3'b000, 2'b00, 32'hDEADBEEF, 32'h0,        32'h4,        5'd31, 1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 32'd8};
        vecs[9]  = '{1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'hAAAA5555, 32'h0,        32'h0,        5'd0,  1'b0, 5'd0,  32'hAAAA5555, 1'b1, 32'd9};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 32'h00000011, 32'h0,        32'h0,        5'd9,  1'b0, 5'd9,  32'h00000011, 1'b1, 32'd10};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 3'b000, 2'b00, 32'h00000022, 32'h0,        32'h0,        5'd3,  1'b0, 5'd3,  32'h00000022, 1'b0, 32'd11};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 3'b011, 2'b10, 32'h0,        32'h80FF7F01, 32'h0,        5'd2,  1'b1, 5'd2,  32'hFFFFFFFF, 1'b1, 32'd11};
        vecs[13] = '{1'b1, 1'b1, 2'b01, 3'b101, 2'b00, 32'h0,        32'h01234567, 32'h0,        5'd4,  1'b1, 5'd4,  32'h01234567, 1'b1, 32'd12};

        // Reset state
        Reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_wb_sel = 2'b00; in_load_type = 3'b000;
        in_addr_lo = 2'b00; in_alu_result = 32'h0; in_mem_rdata = 32'h0; in_pc_plus4 = 32'h0;
        in_dest = 5'd0;
        #2;
        check_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        step();
        check_all("reset_clk", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        @(negedge clock);
        Reset = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].sel, vecs[i].lt, vecs[i].alo, vecs[i].alu,
                  vecs[i].rdata, vecs[i].pc4, vecs[i].dest, 1'b0, 1'b0);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr,
                      vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_rc);
        end

        // Stall for three cycles: contents frozen, counted once on release
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000600D, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0);
        step();
        check_all("stall_cap", 1'b1, 5'd6, 32'h0000600D, 1'b1, 32'd13);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 2'b10, 3'b000, 2'b00, 32'hBAD0BAD0, 32'h0, 32'h77777777, 5'd21, 1'b1, 1'b0);
            step();
            check_all($sformatf("stall%0d", k), 1'b1, 5'd6, 32'h0000600D, 1'b1, 32'd13);
        end
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        check_all("stall_rel", 1'b0, 5'd0, 32'h0, 1'b0, 32'd14);

        // Stall together with flush: flush wins, nothing retires
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h00000088, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0);
        step();
        check_all("sf_cap", 1'b1, 5'd8, 32'h00000088, 1'b1, 32'd14);
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h00000099, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
        step();
        check_all("sf_flush", 1'b0, 5'd8, 32'h00000088, 1'b0, 32'd14);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        check_all("sf_after", 1'b0, 5'd0, 32'h0, 1'b0, 32'd14);

        // Counter wrap: preload all-ones, then retire one instruction
        @(negedge clock);
        force dut.retire_count_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_count_q;
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h00000042, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0);
        step();
        check_all("wrap_cap", 1'b1, 5'd11, 32'h00000042, 1'b1, 32'hFFFFFFFF);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        check_all("wrap", 1'b0, 5'd0, 32'h0, 1'b0, 32'h00000000);

        // Reset asserted mid-stall clears everything without a clock edge
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000ABCD, 32'h0, 32'h0, 5'd10, 1'b0, 1'b0);
        step();
        check_all("rst_cap", 1'b1, 5'd10, 32'h0000ABCD, 1'b1, 32'd0);
        drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000ABCD, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
        step();
        check_all("rst_stall", 1'b1, 5'd10, 32'h0000ABCD, 1'b1, 32'd0);
        #1;
        Reset = 1'b0;
        #1;
        check_all("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        step();
        check_all("rst_rel", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);

        // Word load with addr_lo=2
`ifdef MEMWB_ALIGN_CHECK_EN
        drive(1'b1, 1'b1, 2'b01, 3'b000, 2'b10, 32'h0, 32'hCAFEF00D, 32'h0, 5'd3, 1'b0, 1'b0);
        step();
        cmp("align.err", {31'd0, align_err}, 32'd1);
        check_all("align", 1'b0, 5'd3, 32'hCAFEF00D, 1'b1, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        cmp("align.err_clr", {31'd0, align_err}, 32'd0);
        check_all("align_after", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
`else
        drive(1'b1, 1'b1, 2'b01, 3'b000, 2'b10, 32'h0, 32'hCAFEF00D, 32'h0, 5'd3, 1'b0, 1'b0);
        step();
        check_all("lw_off2", 1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 32'd0);
        drive(1'b1, 1'b1, 2'b01, 3'b010, 2'b11, 32'h0, 32'hCAFEF00D, 32'h0, 5'd3, 1'b0, 1'b0);
        step();
        check_all("lhu_off3", 1'b1, 5'd3, 32'h0000CAFE, 1'b1, 32'd1);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        check_all("lw_after", 1'b0, 5'd0, 32'h0, 1'b0, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_stage
